// File: rtl/rs_pkg.sv
// Shared opcode encodings and sizing for decoder, ROB and reservation station.
package rs_pkg;
    localparam int RS_SIZE   = 8;
    localparam int ROB_WIDTH = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_BEQ  = 4'd10,
        OP_BNE  = 4'd11,
        OP_BLT  = 4'd12,
        OP_BGE  = 4'd13,
        OP_BLTU = 4'd14,
        OP_BGEU = 4'd15
    } op_e;

    function automatic logic is_branch(input op_e op);
        return op >= OP_BEQ;
    endfunction
endpackage

// File: rtl/rs_if.sv
// Issue, load-broadcast and result-broadcast bundle around the reservation station.
interface rs_if #(
    parameter int ROB_WIDTH = rs_pkg::ROB_WIDTH
);
    import rs_pkg::*;

    logic                 dec_valid;
    op_e                  dec_op;
    logic [31:0]          dec_vj;
    logic [31:0]          dec_vk;
    logic [ROB_WIDTH-1:0] dec_qj;
    logic [ROB_WIDTH-1:0] dec_qk;
    logic                 dec_qj_busy;
    logic                 dec_qk_busy;
    logic [ROB_WIDTH-1:0] dec_rob_id;
    logic [31:0]          dec_pc;
    logic [31:0]          dec_imm;
    logic                 lsb_ready;
    logic [ROB_WIDTH-1:0] lsb_rob_id;
    logic [31:0]          lsb_value;
    logic                 rs_full;
    logic                 rs_ready;
    logic [ROB_WIDTH-1:0] rs_rob_id;
    logic [31:0]          rs_value;

    modport master (
        output dec_valid, dec_op, dec_vj, dec_vk, dec_qj, dec_qk,
        output dec_qj_busy, dec_qk_busy, dec_rob_id, dec_pc, dec_imm,
        output lsb_ready, lsb_rob_id, lsb_value,
        input  rs_full, rs_ready, rs_rob_id, rs_value
    );

    modport slave (
        input  dec_valid, dec_op, dec_vj, dec_vk, dec_qj, dec_qk,
        input  dec_qj_busy, dec_qk_busy, dec_rob_id, dec_pc, dec_imm,
        input  lsb_ready, lsb_rob_id, lsb_value,
        output rs_full, rs_ready, rs_rob_id, rs_value
    );
endinterface

// File: rtl/rs_alu.sv
// Combinational ALU and branch-target unit for the reservation station.
module rs_alu
    import rs_pkg::*;
(
    input  op_e         op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic [31:0] result
);
    logic taken;
    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        taken = 1'b0;
        unique case (op)
            OP_BEQ:  taken = (a == b);
            OP_BNE:  taken = (a != b);
            OP_BLT:  taken = ($signed(a) < $signed(b));
            OP_BGE:  taken = ($signed(a) >= $signed(b));
            OP_BLTU: taken = (a < b);
            OP_BGEU: taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        result = '0;
        unique case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            OP_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: result = {31'd0, a < b};
            default: result = taken ? pc + imm : pc + 32'd4;
        endcase
    end
endmodule

// File: rtl/rs.sv
// Reservation station: tag-based operand wakeup, in-order-priority dispatch, registered result.
module rs #(
    parameter int RS_SIZE   = rs_pkg::RS_SIZE,
    parameter int ROB_WIDTH = rs_pkg::ROB_WIDTH
) (
    input logic  clk_in,
    input logic  rst_in,
    input logic  rdy_in,
    input logic  clear,
    rs_if.slave  bus
);
    import rs_pkg::*;

    localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]   busy, qj_busy, qk_busy;
    op_e                  op     [RS_SIZE];
    logic [31:0]          vj     [RS_SIZE];
    logic [31:0]          vk     [RS_SIZE];
    logic [31:0]          pc     [RS_SIZE];
    logic [31:0]          imm    [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj     [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk     [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob_id [RS_SIZE];

    logic                 res_ready;
    logic [ROB_WIDTH-1:0] res_rob_id;
    logic [31:0]          res_value;

    logic          free_found, disp_found;
    logic [IW-1:0] free_idx, disp_idx;
    logic          iss_qj_busy, iss_qk_busy;
    logic [31:0]   iss_vj, iss_vk, alu_result;

    assign bus.rs_full   = &busy;
    assign bus.rs_ready  = res_ready;
    assign bus.rs_rob_id = res_rob_id;
    assign bus.rs_value  = res_value;

    // Descending scan so the lowest index wins both searches.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        disp_found = 1'b0;
        disp_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (busy[i] && !qj_busy[i] && !qk_busy[i]) begin
                disp_found = 1'b1;
                disp_idx   = IW'(i);
            end
        end
    end

    // Operands whose producer broadcasts on the issue cycle are captured directly.
    always_comb begin
        iss_vj      = bus.dec_vj;
        iss_qj_busy = bus.dec_qj_busy;
        iss_vk      = bus.dec_vk;
        iss_qk_busy = bus.dec_qk_busy;
        if (bus.dec_qj_busy && res_ready && bus.dec_qj == res_rob_id) begin
            iss_vj      = res_value;
            iss_qj_busy = 1'b0;
        end else if (bus.dec_qj_busy && bus.lsb_ready && bus.dec_qj == bus.lsb_rob_id) begin
            iss_vj      = bus.lsb_value;
            iss_qj_busy = 1'b0;
        end
        if (bus.dec_qk_busy && res_ready && bus.dec_qk == res_rob_id) begin
            iss_vk      = res_value;
            iss_qk_busy = 1'b0;
        end else if (bus.dec_qk_busy && bus.lsb_ready && bus.dec_qk == bus.lsb_rob_id) begin
            iss_vk      = bus.lsb_value;
            iss_qk_busy = 1'b0;
        end
    end

    rs_alu alu (
        .op     (op[disp_idx]),
        .a      (vj[disp_idx]),
        .b      (vk[disp_idx]),
        .pc     (pc[disp_idx]),
        .imm    (imm[disp_idx]),
        .result (alu_result)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy       <= '0;
            res_ready  <= 1'b0;
            res_rob_id <= '0;
            res_value  <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                busy      <= '0;
                res_ready <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && qj_busy[i]) begin
                        if (res_ready && qj[i] == res_rob_id) begin
                            vj[i]      <= res_value;
                            qj_busy[i] <= 1'b0;
                        end else if (bus.lsb_ready && qj[i] == bus.lsb_rob_id) begin
                            vj[i]      <= bus.lsb_value;
                            qj_busy[i] <= 1'b0;
                        end
                    end
                    if (busy[i] && qk_busy[i]) begin
                        if (res_ready && qk[i] == res_rob_id) begin
                            vk[i]      <= res_value;
                            qk_busy[i] <= 1'b0;
                        end else if (bus.lsb_ready && qk[i] == bus.lsb_rob_id) begin
                            vk[i]      <= bus.lsb_value;
                            qk_busy[i] <= 1'b0;
                        end
                    end
                end
                res_ready <= disp_found;
                if (disp_found) begin
                    busy[disp_idx] <= 1'b0;
                    res_rob_id     <= rob_id[disp_idx];
                    res_value      <= alu_result;
                end
                if (bus.dec_valid && free_found) begin
                    busy[free_idx]    <= 1'b1;
                    op[free_idx]      <= bus.dec_op;
                    vj[free_idx]      <= iss_vj;
                    vk[free_idx]      <= iss_vk;
                    qj[free_idx]      <= bus.dec_qj;
                    qk[free_idx]      <= bus.dec_qk;
                    qj_busy[free_idx] <= iss_qj_busy;
                    qk_busy[free_idx] <= iss_qk_busy;
                    rob_id[free_idx]  <= bus.dec_rob_id;
                    pc[free_idx]      <= bus.dec_pc;
                    imm[free_idx]     <= bus.dec_imm;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs.sv
// Directed self-checking bench for the reservation station.
module tb_rs;
    import rs_pkg::*;

    logic clk = 1'b0;
    logic rst_in, rdy_in, clear;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rs_if bus ();

    rs dut (
        .clk_in (clk),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clear  (clear),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.dec_valid   = 1'b0;
        bus.dec_op      = OP_ADD;
        bus.dec_vj      = '0;
        bus.dec_vk      = '0;
        bus.dec_qj      = '0;
        bus.dec_qk      = '0;
        bus.dec_qj_busy = 1'b0;
        bus.dec_qk_busy = 1'b0;
        bus.dec_rob_id  = '0;
        bus.dec_pc      = '0;
        bus.dec_imm     = '0;
        bus.lsb_ready   = 1'b0;
        bus.lsb_rob_id  = '0;
        bus.lsb_value   = '0;
    endtask

    task automatic issue(input op_e op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [3:0] qj, input logic qjb, input logic [3:0] rob,
                         input logic [31:0] pc, input logic [31:0] imm);
        bus.dec_valid   = 1'b1;
        bus.dec_op      = op;
        bus.dec_vj      = vj;
        bus.dec_vk      = vk;
        bus.dec_qj      = qj;
        bus.dec_qj_busy = qjb;
        bus.dec_qk      = '0;
        bus.dec_qk_busy = 1'b0;
        bus.dec_rob_id  = rob;
        bus.dec_pc      = pc;
        bus.dec_imm     = imm;
    endtask

    task automatic lsb(input logic [3:0] tag, input logic [31:0] val);
        bus.lsb_ready  = 1'b1;
        bus.lsb_rob_id = tag;
        bus.lsb_value  = val;
    endtask

    op_e         t_op  [7] = '{OP_SRA, OP_SRL, OP_SLT, OP_SLTU, OP_BGEU, OP_BEQ, OP_SLL};
    logic [31:0] t_vj  [7] = '{32'h8000_0000, 32'h8000_0000, 32'hffff_ffff, 32'hffff_ffff,
                               32'hffff_ffff, 32'd5, 32'd1};
    logic [31:0] t_vk  [7] = '{32'd4, 32'd4, 32'd1, 32'd1, 32'd1, 32'd6, 32'h21};
    logic [31:0] t_pc  [7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'h200, 32'hffff_fffc, 32'd0};
    logic [31:0] t_imm [7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'h10, 32'h40, 32'd0};
    logic [31:0] t_exp [7] = '{32'hf800_0000, 32'h0800_0000, 32'd1, 32'd0,
                               32'h210, 32'd0, 32'd2};

    initial begin
        quiet();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        clear  = 1'b0;
        step();
        step();
        check("rst_full", bus.rs_full, 0);
        check("rst_ready", bus.rs_ready, 0);
        check("rst_rob", 32'(bus.rs_rob_id), 0);
        check("rst_value", bus.rs_value, 0);
        rst_in = 1'b1;

        issue(OP_ADD, 32'd5, 32'd7, 4'd0, 1'b0, 4'd1, 32'd0, 32'd0);
        step();
        bus.dec_valid = 1'b0;
        check("add_c1_ready", bus.rs_ready, 0);
        step();
        check("add_ready", bus.rs_ready, 1);
        check("add_value", bus.rs_value, 12);
        check("add_rob", 32'(bus.rs_rob_id), 1);
        step();
        check("add_idle", bus.rs_ready, 0);

        issue(OP_SUB, 32'd0, 32'd4, 4'd3, 1'b1, 4'd2, 32'd0, 32'd0);
        step();
        bus.dec_valid = 1'b0;
        step();
        step();
        check("sub_wait", bus.rs_ready, 0);
        lsb(4'd3, 32'd10);
        step();
        bus.lsb_ready = 1'b0;
        check("sub_wake", bus.rs_ready, 0);
        step();
        check("sub_ready", bus.rs_ready, 1);
        check("sub_value", bus.rs_value, 6);
        check("sub_rob", 32'(bus.rs_rob_id), 2);

        issue(OP_BLT, 32'hffff_ffff, 32'd1, 4'd0, 1'b0, 4'd3, 32'h100, 32'h20);
        step();
        issue(OP_BLTU, 32'hffff_ffff, 32'd1, 4'd0, 1'b0, 4'd4, 32'h100, 32'h20);
        step();
        bus.dec_valid = 1'b0;
        check("blt_value", bus.rs_value, 32'h120);
        check("blt_rob", 32'(bus.rs_rob_id), 3);
        step();
        check("bltu_value", bus.rs_value, 32'h104);
        check("bltu_rob", 32'(bus.rs_rob_id), 4);
        step();

        for (int k = 0; k < 7; k++) begin
            issue(t_op[k], t_vj[k], t_vk[k], 4'd0, 1'b0, 4'(k), t_pc[k], t_imm[k]);
            step();
            if (k > 0) begin
                check($sformatf("alu%0d_ready", k - 1), bus.rs_ready, 1);
                check($sformatf("alu%0d_value", k - 1), bus.rs_value, t_exp[k-1]);
            end
        end
        bus.dec_valid = 1'b0;
        step();
        check("alu6_value", bus.rs_value, t_exp[6]);
        step();

        for (int i = 0; i < 8; i++) begin
            issue(OP_ADD, 32'd0, 32'(i), 4'(8 + i), 1'b1, 4'(i), 32'd0, 32'd0);
            step();
        end
        check("full_set", bus.rs_full, 1);
        issue(OP_ADD, 32'd1, 32'd1, 4'd0, 1'b0, 4'd15, 32'd0, 32'd0);
        step();
        bus.dec_valid = 1'b0;
        step();
        check("full_ignore_ready", bus.rs_ready, 0);
        check("full_ignore_full", bus.rs_full, 1);
        lsb(4'd8, 32'd100);
        step();
        bus.lsb_ready = 1'b0;
        check("full_wake", bus.rs_full, 1);
        step();
        check("full_free", bus.rs_full, 0);
        check("full_disp_ready", bus.rs_ready, 1);
        check("full_disp_value", bus.rs_value, 100);
        check("full_disp_rob", 32'(bus.rs_rob_id), 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("flush_full", bus.rs_full, 0);

        for (int i = 0; i < 3; i++) begin
            issue(OP_ADD, 32'd0, 32'd1, 4'd2, 1'b1, 4'(9 + i), 32'd0, 32'd0);
            step();
        end
        issue(OP_ADD, 32'd1, 32'd1, 4'd0, 1'b0, 4'd12, 32'd0, 32'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        bus.dec_valid = 1'b0;
        check("clr_ready", bus.rs_ready, 0);
        check("clr_full", bus.rs_full, 0);
        lsb(4'd2, 32'd50);
        step();
        bus.lsb_ready = 1'b0;
        check("clr_tag2_a", bus.rs_ready, 0);
        step();
        check("clr_tag2_b", bus.rs_ready, 0);

        issue(OP_ADD, 32'd2, 32'd2, 4'd0, 1'b0, 4'd5, 32'd0, 32'd0);
        step();
        bus.dec_valid = 1'b0;
        rst_in = 1'b0;
        rdy_in = 1'b0;
        step();
        check("rst_ovr_ready", bus.rs_ready, 0);
        check("rst_ovr_value", bus.rs_value, 0);
        check("rst_ovr_full", bus.rs_full, 0);
        rst_in = 1'b1;
        rdy_in = 1'b1;

        issue(OP_ADD, 32'd3, 32'd4, 4'd0, 1'b0, 4'd6, 32'd0, 32'd0);
        step();
        bus.dec_valid = 1'b0;
        rdy_in = 1'b0;
        clear  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold%0d_ready", i), bus.rs_ready, 0);
        end
        clear  = 1'b0;
        rdy_in = 1'b1;
        step();
        check("resume_ready", bus.rs_ready, 1);
        check("resume_value", bus.rs_value, 7);
        check("resume_rob", 32'(bus.rs_rob_id), 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
